ws2812_driver: RTL and testbench
================================

# ws2812_driver

Single-wire WS2812 bit-code serializer. It accepts one data bit per handshake and drives the LED data line with a high pulse followed by a low pulse, with cycle counts selected by the bit value. It sits between a pixel/frame shifter upstream (which supplies GRB bits MSB-first) and the chip pad. Frame latch (reset gap) is produced upstream by withholding `code_in_valid`.

## Interface
Parameters (widths are COUNTER_W bits; defaults assume a 50 MHz clock):
- `V_0_HIGH`, default 20: high time of a 0-code, in cycles (0.4 µs).
- `V_0_LOW`, default 43: low time of a 0-code, in cycles (0.85 µs).
- `V_1_HIGH`, default 40: high time of a 1-code, in cycles (0.8 µs).
- `V_1_LOW`, default 23: low time of a 1-code, in cycles (0.45 µs).
- `COUNTER_W`, default 6: phase counter width. All four V_* values must be in 1..2^COUNTER_W−1.

Ports:
- `clk_in`, in, 1: the single clock.
- `rst_n_in`, in, 1: reset; asynchronous, active-low.
- `code_in`, in, 1: bit to send; sampled only on an accepting edge.
- `code_in_valid`, in, 1: request; accepted on a rising edge when `ready_out`=1.
- `ws2812_out`, out, 1: registered LED data line.
- `ready_out`, out, 1: driver idle, can accept a bit this cycle.

## Operation
- FSM states: IDLE, HIGH, LOW. The phase counter is COUNTER_W bits. The latched bit `code_q` selects V_x_HIGH / V_x_LOW.
- `ready_out` = (state==IDLE), decoded combinationally from the state register.
- IDLE: `ws2812_out`=0.
  - If `code_in_valid`: latch `code_in` into `code_q`, go to HIGH, set `ws2812_out`=1, counter=1.
  - `code_in_valid` with `ready_out`=0 is ignored. No queuing; `code_in` is don't-care then.
- HIGH: `ws2812_out`=1. When counter==V_x_HIGH:
  - If V_x_LOW≥2: go to LOW, `ws2812_out`=0, counter=1.
  - If V_x_LOW≤1: go straight to IDLE, `ws2812_out`=0.
  - Otherwise increment the counter.
- LOW: `ws2812_out`=0. When counter==V_x_LOW−1, go to IDLE; otherwise increment.
- The IDLE cycle counts as the final low cycle. With back-to-back valid, the low time is exactly V_x_LOW cycles and the bit period is V_x_HIGH+V_x_LOW. Each extra idle cycle lengthens the low time.
- Reset, including mid-bit: state=IDLE, counter=0, `code_q`=0, `ws2812_out`=0, so `ready_out`=1 while in reset. A partial pulse is truncated.

## Timing
- Accepting edge k: `ws2812_out` rises after edge k, i.e. one cycle of latency from the valid sample.
- `ws2812_out` is high for exactly V_x_HIGH cycles (edges k..k+V_x_HIGH−1 drive it high) and falls after edge k+V_x_HIGH.
- `ready_out` rises V_x_HIGH+max(V_x_LOW−1,0) cycles after edge k.
- Earliest next accept is V_x_HIGH+max(V_x_LOW,1) cycles after edge k.
- `ws2812_out` is glitch-free (flop output).

## Configuration
- `WS2812_INVERT_EN`:
  - Defined: `ws2812_out` polarity is inverted for an inverting level shifter. Idle/low level is 1, high phase is 0, and the reset value is 1.
  - Undefined: non-inverted, as described above.
  - FSM, counter and `ready_out` behaviour are identical either way.

## Test plan
All cases use V_0_HIGH=2, V_0_LOW=1, V_1_HIGH=4, V_1_LOW=5, COUNTER_W=3.
- Reset: `rst_n_in`=0 → `ws2812_out`=0 and `ready_out`=1 immediately (asynchronous), and both hold while in reset.
- Single 0-code, valid one cycle → `ws2812_out` high 2 cycles then low; `ready_out` low 2 cycles, high on the cycle `ws2812_out` falls.
- Single 1-code → `ws2812_out` high 4 cycles; `ready_out` low 8 cycles. A next accept at the first ready cycle gives low exactly 5 cycles.
- `code_in_valid`=1 with `code_in` toggling while busy → ignored; waveform set by the bit latched at accept.
- 10 random bits, each sent at the first cycle `ready_out`=1 → each pulse high 2/4 cycles per bit and low ≥1/≥5 cycles; waveform matches the bit sequence.
- Reset asserted mid-HIGH of a 1-code → `ws2812_out`=0 at once. After release, a new 0-code yields a 2-cycle high pulse.
- With `WS2812_INVERT_EN` defined → repeat the 1-code case; the waveform is the complement and the reset level is 1.

Source files
------------

// File: rtl/ws2812_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ws2812_driver                                                              |
// | One-bit-per-handshake WS2812 serializer: a high phase then a low phase     |
// | per bit, with cycle counts chosen by the bit. WS2812_INVERT_EN inverts the |
// | output line for an inverting level shifter.                                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ws2812_driver #(
  parameter int unsigned          COUNTER_W = 6,
  parameter logic [COUNTER_W-1:0] V_0_HIGH  = COUNTER_W'(20),
  parameter logic [COUNTER_W-1:0] V_0_LOW   = COUNTER_W'(43),
  parameter logic [COUNTER_W-1:0] V_1_HIGH  = COUNTER_W'(40),
  parameter logic [COUNTER_W-1:0] V_1_LOW   = COUNTER_W'(23)
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic code_in,
  input  logic code_in_valid,
  output logic ws2812_out,
  output logic ready_out
);

`ifdef WS2812_INVERT_EN
  localparam logic C_IDLE_LEVEL = 1'b1;
`else
  localparam logic C_IDLE_LEVEL = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [COUNTER_W-1:0]   cnt_q, cnt_d;
  logic                   code_q, code_d;
  logic                   line_q, line_d;
  logic [COUNTER_W-1:0]   w_high_lim;
  logic [COUNTER_W-1:0]   w_low_lim;

  assign w_high_lim = code_q ? V_1_HIGH : V_0_HIGH;
  assign w_low_lim  = code_q ? V_1_LOW  : V_0_LOW;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    line_d  = C_IDLE_LEVEL;
    case (state_q)
      ST_IDLE: begin
        if (code_in_valid) begin
          code_d  = code_in;
          state_d = ST_HIGH;
          cnt_d   = COUNTER_W'(1);
          line_d  = ~C_IDLE_LEVEL;
        end
      end
      ST_HIGH: begin
        if (cnt_q == w_high_lim) begin
          // A low time of 0 or 1 is covered entirely by the IDLE cycle.
          if (w_low_lim > COUNTER_W'(1)) begin
            state_d = ST_LOW;
            cnt_d   = COUNTER_W'(1);
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d  = cnt_q + COUNTER_W'(1);
          line_d = ~C_IDLE_LEVEL;
        end
      end
      ST_LOW: begin
        // Stop one short: the IDLE cycle supplies the final low cycle.
        if (cnt_q == w_low_lim - COUNTER_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + COUNTER_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      code_q  <= 1'b0;
      line_q  <= C_IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      line_q  <= line_d;
    end
  end

  assign ws2812_out = line_q;
  assign ready_out  = (state_q == ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ws2812_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ws2812_driver                                                           |
// | Directed checks of ws2812_driver with short pulse parameters.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ws2812_driver;

  localparam int H0 = 2;
  localparam int L0 = 1;
  localparam int H1 = 4;
  localparam int L1 = 5;

`ifdef WS2812_INVERT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic clk_in;
  logic rst_n_in;
  logic code_in;
  logic code_in_valid;
  logic ws2812_out;
  logic ready_out;

  int n_cmp = 0;
  int n_err = 0;

  ws2812_driver #(
    .COUNTER_W (3),
    .V_0_HIGH  (3'd2),
    .V_0_LOW   (3'd1),
    .V_1_HIGH  (3'd4),
    .V_1_LOW   (3'd5)
  ) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .code_in       (code_in),
    .code_in_valid (code_in_valid),
    .ws2812_out    (ws2812_out),
    .ready_out     (ready_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
    end
  endtask

  // Logical (non-inverted) view of the line.
  function automatic logic lvl();
    return ws2812_out ^ INV;
  endfunction

  // Called at a negedge where the driver is idle; returns at the negedge
  // where ready_out is expected back high.
  task automatic send_bit(input logic b, input bit noise);
    int h;
    int l;
    logic c;
    h = b ? H1 : H0;
    l = b ? L1 : L0;
    c = b;
    chk("pre_ready", ready_out, 1'b1);
    chk("pre_line", lvl(), 1'b0);
    code_in_valid = 1'b1;
    code_in       = b;
    @(negedge clk_in);
    for (int i = 0; i < h; i++) begin
      chk(b ? "high1" : "high0", lvl(), 1'b1);
      chk("busy_hi", ready_out, 1'b0);
      if (noise) begin
        c             = ~c;
        code_in       = c;
        code_in_valid = 1'b1;
      end else begin
        code_in_valid = 1'b0;
      end
      @(negedge clk_in);
    end
    for (int i = 0; i < l - 1; i++) begin
      chk(b ? "low1" : "low0", lvl(), 1'b0);
      chk("busy_lo", ready_out, 1'b0);
      if (noise) begin
        c       = ~c;
        code_in = c;
      end
      @(negedge clk_in);
    end
    code_in_valid = 1'b0;
    chk("ready_back", ready_out, 1'b1);
    chk("line_at_ready", lvl(), 1'b0);
  endtask

  initial begin
    rst_n_in      = 1'b0;
    code_in       = 1'b0;
    code_in_valid = 1'b0;

    // Asynchronous reset, before any clock edge.
    #3;
    chk("rst_async_line", ws2812_out, INV);
    chk("rst_async_ready", ready_out, 1'b1);
    @(negedge clk_in);
    chk("rst_hold_line", ws2812_out, INV);
    chk("rst_hold_ready", ready_out, 1'b1);
    code_in_valid = 1'b1;
    @(negedge clk_in);
    chk("rst_valid_ignored", ws2812_out, INV);
    chk("rst_valid_ready", ready_out, 1'b1);
    code_in_valid = 1'b0;
    rst_n_in      = 1'b1;
    @(negedge clk_in);
    chk("idle_line", lvl(), 1'b0);
    chk("idle_ready", ready_out, 1'b1);

    // Single 0-code, then single 1-code, then back-to-back 1-codes.
    send_bit(1'b0, 1'b0);
    @(negedge clk_in);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);

    // Busy with valid held and code toggling: waveform follows latched bit.
    @(negedge clk_in);
    send_bit(1'b1, 1'b1);
    @(negedge clk_in);
    send_bit(1'b0, 1'b1);

    // Ten random bits, each at the first ready cycle.
    for (int k = 0; k < 10; k++) begin
      send_bit(1'($urandom_range(0, 1)), 1'b0);
    end

    // Reset mid-HIGH of a 1-code.
    @(negedge clk_in);
    code_in_valid = 1'b1;
    code_in       = 1'b1;
    @(negedge clk_in);
    code_in_valid = 1'b0;
    chk("mid_high_a", lvl(), 1'b1);
    @(negedge clk_in);
    chk("mid_high_b", lvl(), 1'b1);
    #2 rst_n_in = 1'b0;
    #1;
    chk("mid_rst_line", ws2812_out, INV);
    chk("mid_rst_ready", ready_out, 1'b1);
    @(negedge clk_in);
    chk("mid_rst_hold", ws2812_out, INV);
    rst_n_in = 1'b1;
    send_bit(1'b0, 1'b0);

    // Extra idle cycles keep the line low and the driver ready.
    @(negedge clk_in);
    chk("gap_line", lvl(), 1'b0);
    chk("gap_ready", ready_out, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
